// File: rtl/stopwatch_counter_if.sv
// Stopwatch counter interface: run/clear/lap controls in, tick and
// frozen-or-live BCD display digits plus status flags out.
interface stopwatch_counter_if;
    logic       run;
    logic       clr;
    logic       lap;
    logic       tick;
    logic [3:0] disp_mt;
    logic [3:0] disp_mo;
    logic [3:0] disp_st;
    logic [3:0] disp_so;
    logic [3:0] disp_ct;
    logic [3:0] disp_co;
    logic       lap_hold;
    logic       ovf;

    // Controller / display side
    modport master (
        output run, clr, lap,
        input  tick, disp_mt, disp_mo, disp_st, disp_so, disp_ct, disp_co,
        input  lap_hold, ovf
    );

    // Counter side
    modport slave (
        input  run, clr, lap,
        output tick, disp_mt, disp_mo, disp_st, disp_so, disp_ct, disp_co,
        output lap_hold, ovf
    );
endinterface

// File: rtl/stopwatch_counter.sv
// Stopwatch time base and MM:SS.cc BCD counter.
// Stage p0: prescaler and internal digits. Stage p1: tick, display
// register (live or lap-frozen), lap_hold and sticky overflow.
module stopwatch_counter #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int TICK_HZ     = 100
) (
    input  logic                clk,
    input  logic                reset,
    stopwatch_counter_if.slave  sw
);

    localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    // Digit packing throughout: {mt, mo, st, so, ct, co}
    logic [PW-1:0] presc_p0;
    logic [23:0]   dig_p0;
    logic [23:0]   dig_inc;
    logic [23:0]   dig_nxt;
    logic          roll_max;
    logic          adv;
    logic          clear;

    logic          tick_p1;
    logic [23:0]   disp_p1;
    logic          lap_hold_p1;
    logic          ovf_p1;

    // One BCD digit: add carry-in, wrap to 0 and carry out above lim.
    function automatic logic [4:0] bcd_step(input logic [3:0] d,
                                            input logic [3:0] lim,
                                            input logic       cin);
        if (!cin)
            return {1'b0, d};
        if (d >= lim)
            return {1'b1, 4'd0};
        return {1'b0, d + 4'd1};
    endfunction

    // Add one centisecond; MSB of the result is the 59:59.99 rollover.
    function automatic logic [24:0] bcd_advance(input logic [23:0] d);
        logic [4:0] co, ct, so, st, mo, mt;
        co = bcd_step(d[3:0],   4'd9, 1'b1);
        ct = bcd_step(d[7:4],   4'd9, co[4]);
        so = bcd_step(d[11:8],  4'd9, ct[4]);
        st = bcd_step(d[15:12], 4'd5, so[4]);
        mo = bcd_step(d[19:16], 4'd9, st[4]);
        mt = bcd_step(d[23:20], 4'd5, mo[4]);
        return {mt[4], mt[3:0], mo[3:0], st[3:0], so[3:0], ct[3:0], co[3:0]};
    endfunction

    assign clear = reset || sw.clr;
    // Advance only when run is still high on the edge the prescaler wraps.
    assign adv   = sw.run && (presc_p0 == PRESC_LAST);

    // Next digit values: incremented on a wrap edge, otherwise unchanged.
    always_comb begin
        {roll_max, dig_inc} = bcd_advance(dig_p0);
        dig_nxt = adv ? dig_inc : dig_p0;
    end

    // ---- stage p0: prescaler and internal digits ----
    // Prescaler counts only while running, so a pause keeps the partial tick.
    always_ff @(posedge clk) begin
        if (clear)
            presc_p0 <= '0;
        else if (sw.run)
            presc_p0 <= adv ? '0 : presc_p0 + PW'(1);
    end

    // Internal digits advance one centisecond per prescaler wrap.
    always_ff @(posedge clk) begin
        if (clear)
            dig_p0 <= '0;
        else
            dig_p0 <= dig_nxt;
    end

    // ---- stage p1: tick, display, lap and overflow ----
    // Tick goes high together with the new digit values.
    always_ff @(posedge clk) begin
        if (clear)
            tick_p1 <= 1'b0;
        else
            tick_p1 <= adv;
    end

    // Overflow is sticky until clear or reset.
    always_ff @(posedge clk) begin
        if (clear)
            ovf_p1 <= 1'b0;
        else if (adv && roll_max)
            ovf_p1 <= 1'b1;
    end

    // Lap pulse toggles the display freeze; clear always releases it.
    always_ff @(posedge clk) begin
        if (clear)
            lap_hold_p1 <= 1'b0;
        else if (sw.lap)
            lap_hold_p1 <= ~lap_hold_p1;
    end

    // Display tracks the digits unless frozen; a lap edge both captures
    // the snapshot on entry and resumes tracking on exit.
    always_ff @(posedge clk) begin
        if (clear)
            disp_p1 <= '0;
        else if (!lap_hold_p1 || sw.lap)
            disp_p1 <= dig_nxt;
    end

    assign sw.tick     = tick_p1;
    assign sw.lap_hold = lap_hold_p1;
    assign sw.ovf      = ovf_p1;
    assign sw.disp_mt  = disp_p1[23:20];
    assign sw.disp_mo  = disp_p1[19:16];
    assign sw.disp_st  = disp_p1[15:12];
    assign sw.disp_so  = disp_p1[11:8];
    assign sw.disp_ct  = disp_p1[7:4];
    assign sw.disp_co  = disp_p1[3:0];

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter with DIV = 10.
module tb_stopwatch_counter;

    logic clk = 1'b0;
    logic reset;

    stopwatch_counter_if sw();

    stopwatch_counter #(
        .CLK_FREQ_HZ(1000),
        .TICK_HZ    (100)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .sw   (sw)
    );

    always #5 clk = ~clk;

    logic [23:0] disp;
    assign disp = {sw.disp_mt, sw.disp_mo, sw.disp_st,
                   sw.disp_so, sw.disp_ct, sw.disp_co};

    int total = 0;
    int bad   = 0;
    int cyc_no = 0;
    int win_start = 0;
    int tick_n = 0;
    int first_t = -1;
    int last_abs = 0;
    int gap_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock, sampled 1 time unit after the rising edge; records ticks.
    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_no++;
        if (sw.tick === 1'b1) begin
            if (tick_n == 0)
                first_t = cyc_no - win_start;
            else if (cyc_no - last_abs != 10)
                gap_bad++;
            last_abs = cyc_no;
            tick_n++;
        end
    endtask

    task automatic run_n(input int n);
        repeat (n) cyc();
    endtask

    task automatic win();
        win_start = cyc_no;
        tick_n    = 0;
        first_t   = -1;
        gap_bad   = 0;
    endtask

    // Time limit so the run always ends even if the clock stalls.
    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        sw.run = 1'b0;
        sw.clr = 1'b0;
        sw.lap = 1'b0;
        run_n(2);
        chk("rst_disp", disp, 24'h000000);
        chk("rst_tick", sw.tick, 0);
        chk("rst_lap_hold", sw.lap_hold, 0);
        chk("rst_ovf", sw.ovf, 0);
        reset = 1'b0;

        // 1: 100 clocks running -> 10 ticks, 10 clocks apart
        sw.run = 1'b1;
        win();
        run_n(100);
        chk("t1_tick_count", tick_n, 10);
        chk("t1_first_tick", first_t, 10);
        chk("t1_tick_gaps", gap_bad, 0);
        chk("t1_disp", disp, 24'h000010);

        // 2: pause keeps partial tick
        sw.run = 1'b0;
        sw.clr = 1'b1;
        cyc();
        sw.clr = 1'b0;
        chk("t2_clr_disp", disp, 24'h000000);
        sw.run = 1'b1;
        win();
        run_n(4);
        sw.run = 1'b0;
        run_n(50);
        chk("t2_pause_ticks", tick_n, 0);
        sw.run = 1'b1;
        run_n(5);
        chk("t2_resume5_ticks", tick_n, 0);
        cyc();
        chk("t2_resume6_tick", sw.tick, 1);
        chk("t2_disp", disp, 24'h000001);
        sw.run = 1'b0;

        // 3: carries into minutes and full rollover
        force dut.dig_p0 = 24'h005999;
        cyc();
        release dut.dig_p0;
        chk("t3_preload_a", disp, 24'h005999);
        sw.run = 1'b1;
        run_n(10);
        chk("t3_min_carry", disp, 24'h010000);
        chk("t3_ovf_clear", sw.ovf, 0);
        sw.run = 1'b0;
        force dut.dig_p0 = 24'h595999;
        cyc();
        release dut.dig_p0;
        chk("t3_preload_b", disp, 24'h595999);
        sw.run = 1'b1;
        run_n(10);
        chk("t3_wrap_disp", disp, 24'h000000);
        chk("t3_wrap_tick", sw.tick, 1);
        chk("t3_wrap_ovf", sw.ovf, 1);
        run_n(10);
        chk("t3_ovf_sticky", sw.ovf, 1);
        chk("t3_after_wrap", disp, 24'h000001);
        sw.run = 1'b0;

        // 4: lap freeze and release
        sw.clr = 1'b1;
        cyc();
        sw.clr = 1'b0;
        chk("t4_clr_ovf", sw.ovf, 0);
        sw.run = 1'b1;
        run_n(370);
        chk("t4_at_37", disp, 24'h000037);
        sw.lap = 1'b1;
        cyc();
        sw.lap = 1'b0;
        chk("t4_hold_on", sw.lap_hold, 1);
        chk("t4_snapshot", disp, 24'h000037);
        win();
        run_n(199);
        chk("t4_held_ticks", tick_n, 20);
        chk("t4_frozen", disp, 24'h000037);
        sw.lap = 1'b1;
        cyc();
        sw.lap = 1'b0;
        chk("t4_hold_off", sw.lap_hold, 0);
        chk("t4_release_disp", disp, 24'h000057);

        // 5: clr (with lap) mid-count while running
        sw.clr = 1'b1;
        cyc();
        sw.clr = 1'b0;
        run_n(12346);
        sw.lap = 1'b1;
        cyc();
        sw.lap = 1'b0;
        chk("t5_hold_on", sw.lap_hold, 1);
        chk("t5_snapshot", disp, 24'h001234);
        sw.clr = 1'b1;
        sw.lap = 1'b1;
        cyc();
        sw.clr = 1'b0;
        sw.lap = 1'b0;
        chk("t5_clr_disp", disp, 24'h000000);
        chk("t5_clr_lap_hold", sw.lap_hold, 0);
        chk("t5_clr_ovf", sw.ovf, 0);
        chk("t5_clr_tick", sw.tick, 0);
        win();
        run_n(9);
        chk("t5_no_early_tick", tick_n, 0);
        cyc();
        chk("t5_first_tick", sw.tick, 1);
        chk("t5_disp", disp, 24'h000001);

        // 6: reset mid-count while frozen
        sw.lap = 1'b1;
        cyc();
        sw.lap = 1'b0;
        run_n(5);
        chk("t6_hold_on", sw.lap_hold, 1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("t6_rst_disp", disp, 24'h000000);
        chk("t6_rst_lap_hold", sw.lap_hold, 0);
        chk("t6_rst_tick", sw.tick, 0);
        chk("t6_rst_ovf", sw.ovf, 0);
        win();
        run_n(9);
        chk("t6_no_early_tick", tick_n, 0);
        cyc();
        chk("t6_first_tick", sw.tick, 1);
        chk("t6_disp", disp, 24'h000001);

        // 7: run drops exactly when the prescaler sits at its last count
        run_n(9);
        sw.run = 1'b0;
        cyc();
        chk("t7_no_tick", sw.tick, 0);
        chk("t7_disp_held", disp, 24'h000001);
        run_n(3);
        sw.run = 1'b1;
        cyc();
        chk("t7_resume_tick", sw.tick, 1);
        chk("t7_disp", disp, 24'h000002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
